// File: rtl/neural_network_pkg.sv
// Shared fixed-point types, limits and the accumulator FSM encoding for the neuron datapath
// (multiplier, saturator, accumulator).
package neural_network_pkg;

    localparam int FIXED_POINT_LENGTH   = 16;
    localparam int FIXED_POINT_POSITION = 10;

    typedef logic signed [FIXED_POINT_LENGTH-1:0] fixed_point_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

    // Clamp limits of the fixed-point word, shared with the multiplier's saturation path.
    localparam fixed_point_t MAX_VALUE = {1'b0, {(FIXED_POINT_LENGTH-1){1'b1}}};
    localparam fixed_point_t MIN_VALUE = {1'b1, {(FIXED_POINT_LENGTH-1){1'b0}}};

endpackage

// File: rtl/fixed_point_saturator.sv
// Combinational signed clamp from IN_LENGTH bits down to OUT_LENGTH bits (IN_LENGTH >= OUT_LENGTH).
module fixed_point_saturator #(
    parameter int IN_LENGTH  = 20,
    parameter int OUT_LENGTH = 16
) (
    input  logic signed [IN_LENGTH-1:0]  value_in,
    output logic signed [OUT_LENGTH-1:0] value_out
);

    // The value fits when every bit from the output sign bit upward agrees.
    logic [IN_LENGTH-OUT_LENGTH:0] top_bits;

    always_comb begin
        top_bits = value_in[IN_LENGTH-1:OUT_LENGTH-1];
        if ((&top_bits) || !(|top_bits)) begin
            value_out = value_in[OUT_LENGTH-1:0];
        end else if (value_in[IN_LENGTH-1]) begin
            value_out = {1'b1, {(OUT_LENGTH-1){1'b0}}};
        end else begin
            value_out = {1'b0, {(OUT_LENGTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Sums NUM_INPUTS signed fixed-point products onto a bias and emits one saturated result per start.
// Optional macro NEURON_ACCUMULATOR_RELU_EN clamps negative results to zero.
module neuron_accumulator #(
    parameter int FIXED_POINT_LENGTH   = 16,
    parameter int FIXED_POINT_POSITION = 10,
    parameter int NUM_INPUTS           = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic [FIXED_POINT_LENGTH-1:0] bias_in,
    input  logic [FIXED_POINT_LENGTH-1:0] product_in,
    input  logic                          product_valid_in,
    output logic [FIXED_POINT_LENGTH-1:0] sum_out,
    output logic                          sum_valid_out,
    output logic                          busy_out
);

    import neural_network_pkg::*;

    localparam int L          = FIXED_POINT_LENGTH;
    localparam int ACC_LENGTH = L + $clog2(NUM_INPUTS + 1);
    localparam int CNT_W      = $clog2(NUM_INPUTS + 1);

    // Bias and products share one Q format, so no alignment shift exists; reject nonsense configs.
    if (NUM_INPUTS < 1 || FIXED_POINT_POSITION >= FIXED_POINT_LENGTH) begin : g_bad_param
        $error("neuron_accumulator: invalid NUM_INPUTS or FIXED_POINT_POSITION");
    end

    accum_state_t                 state_reg, state_next;
    logic signed [ACC_LENGTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]             count_reg, count_next;
    logic [L-1:0]                 sum_reg, sum_next;
    logic                         valid_reg, valid_next;
    logic                         busy_reg;

    logic signed [L-1:0]          sat_value;
    logic [L-1:0]                 result_value;

    fixed_point_saturator #(
        .IN_LENGTH  (ACC_LENGTH),
        .OUT_LENGTH (L)
    ) u_saturator (
        .value_in  (acc_reg),
        .value_out (sat_value)
    );

`ifdef NEURON_ACCUMULATOR_RELU_EN
    assign result_value = sat_value[L-1] ? '0 : sat_value;
`else
    assign result_value = sat_value;
`endif

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        sum_next   = sum_reg;
        valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_in) begin
                    acc_next   = {{(ACC_LENGTH-L){bias_in[L-1]}}, bias_in};
                    count_next = '0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (product_valid_in) begin
                    acc_next   = acc_reg + {{(ACC_LENGTH-L){product_in[L-1]}}, product_in};
                    count_next = count_reg + CNT_W'(1);
                    if (count_reg == CNT_W'(NUM_INPUTS - 1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                sum_next   = result_value;
                valid_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            sum_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            sum_reg   <= sum_next;
            valid_reg <= valid_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign sum_out       = sum_reg;
    assign sum_valid_out = valid_reg;
    assign busy_out      = busy_reg;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized self-checking bench for neuron_accumulator (NUM_INPUTS=4, Q5.10) with an
// integer-arithmetic reference model of sum, clamp and optional ReLU.
module tb_neuron_accumulator;

    localparam int L = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_in;
    logic         start_in;
    logic [L-1:0] bias_in;
    logic [L-1:0] product_in;
    logic         product_valid_in;
    logic [L-1:0] sum_out;
    logic         sum_valid_out;
    logic         busy_out;

    neuron_accumulator #(
        .FIXED_POINT_LENGTH   (L),
        .FIXED_POINT_POSITION (10),
        .NUM_INPUTS           (N)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .bias_in          (bias_in),
        .product_in       (product_in),
        .product_valid_in (product_valid_in),
        .sum_out          (sum_out),
        .sum_valid_out    (sum_valid_out),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           checks = 0;
    int           errors = 0;
    logic [L-1:0] prods[N];
    logic [L-1:0] last_sum;
    int           last_valid_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum of bias and products, clamped to the signed word range.
    function automatic logic [L-1:0] ref_sum(input logic [L-1:0] b);
        longint s;
        s = longint'($signed(b));
        for (int i = 0; i < N; i++) s += longint'($signed(prods[i]));
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef NEURON_ACCUMULATOR_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[L-1:0];
    endfunction

    function automatic logic [L-1:0] rand_term();
        logic [L-1:0] v;
        v = L'($urandom);
        case ($urandom_range(0, 3))
            0:       return v;
            1:       return ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            default: return {{4{v[11]}}, v[11:0]};
        endcase
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("idle_valid", sum_valid_out, 0);
            check_eq("idle_busy", busy_out, 0);
        end
    endtask

    // One neuron: start, NUM_INPUTS products with random gaps, then the result cycle.
    task automatic run_neuron(input string tag, input logic [L-1:0] b, input int max_gap,
                              input bit junk_start, input bit pv_with_start);
        logic [L-1:0] exp;
        int           gap;
        exp = ref_sum(b);
        start_in = 1'b1;
        bias_in = b;
        product_valid_in = pv_with_start;
        product_in = 16'h7000;
        tick();
        start_in = 1'b0;
        product_valid_in = 1'b0;
        bias_in = L'($urandom);
        check_eq({tag, "_busy_start"}, busy_out, 1);
        check_eq({tag, "_valid_start"}, sum_valid_out, 0);
        check_eq({tag, "_sum_hold"}, sum_out, last_sum);
        for (int i = 0; i < N; i++) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                start_in = junk_start;
                product_valid_in = 1'b0;
                tick();
                check_eq({tag, "_busy_gap"}, busy_out, 1);
            end
            start_in = junk_start;
            product_valid_in = 1'b1;
            product_in = prods[i];
            tick();
            check_eq({tag, "_busy_acc"}, busy_out, 1);
            check_eq({tag, "_valid_acc"}, sum_valid_out, 0);
        end
        start_in = junk_start;
        product_valid_in = junk_start;
        product_in = 16'h7000;
        tick();
        start_in = 1'b0;
        product_valid_in = 1'b0;
        check_eq({tag, "_valid"}, sum_valid_out, 1);
        check_eq({tag, "_sum"}, sum_out, exp);
        check_eq({tag, "_busy_end"}, busy_out, 0);
        last_valid_cyc = cyc;
        last_sum = exp;
    endtask

    initial begin
        int first_valid;
        rst_in = 1'b1;
        start_in = 1'b0;
        bias_in = '0;
        product_in = '0;
        product_valid_in = 1'b0;
        last_sum = '0;
        last_valid_cyc = 0;
        tick();
        tick();
        rst_in = 1'b0;
        check_eq("reset_sum", sum_out, 0);
        check_eq("reset_valid", sum_valid_out, 0);
        check_eq("reset_busy", busy_out, 0);
        idle_cycles(2);

        // 1.0 bias plus four 1.0 products on consecutive cycles
        for (int i = 0; i < N; i++) prods[i] = 16'h0400;
        run_neuron("t1", 16'h0400, 0, 0, 0);
        check_eq("t1_expected", sum_out, 16'h1400);
        idle_cycles(1);

        // Positive and negative saturation
        for (int i = 0; i < N; i++) prods[i] = 16'h7FFF;
        run_neuron("t2_pos", 16'h7FFF, 0, 0, 0);
        check_eq("t2_pos_const", sum_out, 16'h7FFF);
        idle_cycles(1);
        for (int i = 0; i < N; i++) prods[i] = 16'h8000;
        run_neuron("t2_neg", 16'h8000, 0, 0, 0);
`ifdef NEURON_ACCUMULATOR_RELU_EN
        check_eq("t2_neg_const", sum_out, 16'h0000);
`else
        check_eq("t2_neg_const", sum_out, 16'h8000);
`endif
        idle_cycles(1);

        // Gapped products, stray valid in IDLE and alongside start
        prods[0] = 16'h0800; prods[1] = 16'hFC00; prods[2] = 16'h0200; prods[3] = 16'hFE00;
        product_valid_in = 1'b1;
        product_in = 16'h7000;
        tick();
        product_valid_in = 1'b0;
        check_eq("t3_idle_pv_busy", busy_out, 0);
        run_neuron("t3", 16'h0000, 3, 0, 1);
        check_eq("t3_expected", sum_out, 16'h0400);
        idle_cycles(1);

        // Reset after two accepted products
        start_in = 1'b1;
        bias_in = 16'h1234;
        tick();
        start_in = 1'b0;
        product_valid_in = 1'b1;
        product_in = 16'h0400;
        tick();
        tick();
        product_valid_in = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_eq("t4_rst_sum", sum_out, 0);
        check_eq("t4_rst_valid", sum_valid_out, 0);
        check_eq("t4_rst_busy", busy_out, 0);
        last_sum = '0;
        idle_cycles(6);
        for (int i = 0; i < N; i++) prods[i] = 16'h0400;
        run_neuron("t4", 16'hFC00, 0, 0, 0);
        check_eq("t4_expected", sum_out, 16'h0C00);
        idle_cycles(1);

        // Start held through ACCUM and DONE is ignored; back-to-back start in the valid cycle
        prods[0] = 16'h0100; prods[1] = 16'h0200; prods[2] = 16'h0300; prods[3] = 16'h0400;
        run_neuron("t5_junk", 16'h0000, 1, 1, 0);
        check_eq("t5_junk_expected", sum_out, 16'h0A00);
        idle_cycles(1);
        run_neuron("t5_a", 16'h0400, 0, 0, 0);
        first_valid = last_valid_cyc;
        prods[0] = 16'hFF00;
        run_neuron("t5_b", 16'h0000, 0, 0, 0);
        check_eq("t5_b_expected", sum_out, 16'h0800);
        check_eq("t5_period", last_valid_cyc - first_valid, 6);
        idle_cycles(1);

        // Randomized neurons against the reference model
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < N; i++) prods[i] = rand_term();
            run_neuron("rand", rand_term(), 2, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
